// File: rtl/ccastles_video_timing_if.sv
// rtl/ccastles_video_timing_if.sv - raster timing bundle between the timing generator and its consumers
//
// Purpose: groups the mode selects and the beam timing outputs of
// ccastles_video_timing so they travel as one port.
//   pal, scandouble        : mode selects, driven by the consumer side
//   ce_pix                 : one-clk pixel enable
//   hcnt, vcnt             : 9-bit horizontal pixel / vertical source-line counters
//   HBlank, HSync          : horizontal blank and active-high sync
//   VBlank, VSync          : vertical blank and active-high sync
//   line_start/frame_start : one-clk pulses when the counters return to zero
// modport master: the timing generator; modport slave: the video consumer.
interface ccastles_video_timing_if;
  logic       pal;
  logic       scandouble;
  logic       ce_pix;
  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic       HBlank;
  logic       HSync;
  logic       VBlank;
  logic       VSync;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  pal, scandouble,
    output ce_pix, hcnt, vcnt, HBlank, HSync, VBlank, VSync, line_start, frame_start
  );

  modport slave (
    output pal, scandouble,
    input  ce_pix, hcnt, vcnt, HBlank, HSync, VBlank, VSync, line_start, frame_start
  );
endinterface

// File: rtl/ccastles_video_timing.sv
// rtl/ccastles_video_timing.sv - Crystal Castles raster timing generator
//
// Purpose: derives the pixel enable from clk and keeps the horizontal and
// vertical beam counters plus blank/sync flags. NTSC/PAL and scandouble
// selections are latched only when the counters wrap to (0,0).
// Ports:
//   clk     : only clock
//   reset_n : synchronous active-low reset
//   vid     : ccastles_video_timing_if.master (pal/scandouble in; ce_pix,
//             hcnt, vcnt, HBlank, HSync, VBlank, VSync, line_start,
//             frame_start out)
module ccastles_video_timing #(
  parameter int CE_DIV        = 8,
  parameter int H_TOTAL       = 320,
  parameter int H_ACTIVE      = 256,
  parameter int HS_START      = 272,
  parameter int HS_LEN        = 24,
  parameter int V_ACTIVE      = 232,
  parameter int V_TOTAL_NTSC  = 262,
  parameter int V_TOTAL_PAL   = 312,
  parameter int VS_START_NTSC = 240,
  parameter int VS_START_PAL  = 264,
  parameter int VS_LEN        = 3
) (
  input logic                     clk,
  input logic                     reset_n,
  ccastles_video_timing_if.master vid
);

  localparam int DIV_W = $clog2(CE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST_NAT = DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST_SD  = DIV_W'(CE_DIV / 2 - 1);
  localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_ACT      = 9'(H_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(HS_START);
  localparam logic [9:0] HS_END     = 10'(HS_START + HS_LEN);
  localparam logic [8:0] V_ACT      = 9'(V_ACTIVE);
  localparam logic [8:0] V_LAST_N   = 9'(V_TOTAL_NTSC - 1);
  localparam logic [8:0] V_LAST_P   = 9'(V_TOTAL_PAL - 1);
  localparam logic [9:0] VS_FIRST_N = 10'(VS_START_NTSC);
  localparam logic [9:0] VS_FIRST_P = 10'(VS_START_PAL);
  localparam logic [9:0] VS_END_N   = 10'(VS_START_NTSC + VS_LEN);
  localparam logic [9:0] VS_END_P   = 10'(VS_START_PAL + VS_LEN);

  logic [DIV_W-1:0] div_q, div_d, div_last;
  logic             ce_pix_q, ce_pix_d;
  logic [8:0]       hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic             rep_q, rep_d;
  logic             pal_l_q, pal_l_d, sd_l_q, sd_l_d;
  logic             hblank_q, hblank_d, hsync_q, hsync_d;
  logic             vblank_q, vblank_d, vsync_q, vsync_d;
  logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic             h_wrap, v_step, v_wrap;
  logic [9:0]       vs_first, vs_end;

  always_comb begin
    div_last = sd_l_q ? DIV_LAST_SD : DIV_LAST_NAT;
    div_d    = (div_q >= div_last) ? '0 : div_q + 1'b1;
    // Registered from div = D-1, so the pulse lands when div has just
    // returned to 0; the counters then move on the following edge.
    ce_pix_d = (div_q == div_last);

    h_wrap = ce_pix_q && (hcnt_q == H_LAST);
    // In scandouble each source line is output twice; rep marks the repeat.
    v_step = h_wrap && (!sd_l_q || rep_q);
    v_wrap = v_step && (vcnt_q == (pal_l_q ? V_LAST_P : V_LAST_N));

    hcnt_d = hcnt_q;
    if (ce_pix_q) hcnt_d = h_wrap ? 9'd0 : hcnt_q + 9'd1;

    rep_d = rep_q;
    if (h_wrap) rep_d = sd_l_q && !rep_q;

    vcnt_d = vcnt_q;
    if (v_step) vcnt_d = v_wrap ? 9'd0 : vcnt_q + 9'd1;

    // Mode selects are taken only at the (0,0) wrap, keeping a frame uniform.
    pal_l_d = v_wrap ? vid.pal        : pal_l_q;
    sd_l_d  = v_wrap ? vid.scandouble : sd_l_q;

    // Flags are derived from the next counter values so they are registered
    // together with the counters they describe.
    vs_first = pal_l_d ? VS_FIRST_P : VS_FIRST_N;
    vs_end   = pal_l_d ? VS_END_P   : VS_END_N;
    hblank_d = (hcnt_d >= H_ACT);
    hsync_d  = ({1'b0, hcnt_d} >= HS_FIRST) && ({1'b0, hcnt_d} < HS_END);
    vblank_d = (vcnt_d >= V_ACT);
    vsync_d  = ({1'b0, vcnt_d} >= vs_first) && ({1'b0, vcnt_d} < vs_end);

    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q         <= '0;
      ce_pix_q      <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      rep_q         <= 1'b0;
      pal_l_q       <= vid.pal;
      sd_l_q        <= vid.scandouble;
      hblank_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vblank_q      <= 1'b0;
      vsync_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      ce_pix_q      <= ce_pix_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      rep_q         <= rep_d;
      pal_l_q       <= pal_l_d;
      sd_l_q        <= sd_l_d;
      hblank_q      <= hblank_d;
      hsync_q       <= hsync_d;
      vblank_q      <= vblank_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.ce_pix      = ce_pix_q;
  assign vid.hcnt        = hcnt_q;
  assign vid.vcnt        = vcnt_q;
  assign vid.HBlank      = hblank_q;
  assign vid.HSync       = hsync_q;
  assign vid.VBlank      = vblank_q;
  assign vid.VSync       = vsync_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_ccastles_video_timing.sv
// tb/tb_ccastles_video_timing.sv - self-checking bench for ccastles_video_timing
module tb_ccastles_video_timing;

  localparam int CE  = 8;
  localparam int H   = 20;
  localparam int HA  = 16;
  localparam int HSS = 17;
  localparam int HSL = 2;
  localparam int VA  = 10;
  localparam int VTN = 14;
  localparam int VTP = 18;
  localparam int VSN = 11;
  localparam int VSP = 13;
  localparam int VSL = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ccastles_video_timing_if vif ();

  ccastles_video_timing #(
    .CE_DIV(CE), .H_TOTAL(H), .H_ACTIVE(HA), .HS_START(HSS), .HS_LEN(HSL),
    .V_ACTIVE(VA), .V_TOTAL_NTSC(VTN), .V_TOTAL_PAL(VTP),
    .VS_START_NTSC(VSN), .VS_START_PAL(VSP), .VS_LEN(VSL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .vid(vif)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Per-cycle property monitor
  logic rst_s = 1'b0, pal_s = 1'b0, sd_s = 1'b0;
  always @(posedge clk) begin
    rst_s <= reset_n;
    pal_s <= vif.pal;
    sd_s  <= vif.scandouble;
  end

  int   ce_gap = 0;
  logic m_pal = 1'b0, m_sd = 1'b0;
  logic prev_ce = 1'b0;
  logic [8:0] prev_h = '0, prev_v = '0;
  logic [3:0] prev_f = '0;
  int err_rst = 0, err_ce = 0, err_hold = 0, err_pulse = 0, err_flag = 0;

  always @(negedge clk) begin
    logic ls_exp, fs_exp, exp_ce;
    int vs0;
    if (!rst_s) begin
      if ({vif.ce_pix, vif.hcnt, vif.vcnt, vif.HBlank, vif.HSync, vif.VBlank,
           vif.VSync, vif.line_start, vif.frame_start} !== '0) err_rst++;
      m_pal = pal_s;
      m_sd  = sd_s;
      ce_gap = 0;
    end else begin
      ce_gap++;
      if (vif.frame_start) begin
        m_pal = pal_s;
        m_sd  = sd_s;
      end
      exp_ce = (ce_gap == (m_sd ? CE / 2 : CE));
      if (vif.ce_pix !== exp_ce) err_ce++;
      if (vif.ce_pix) ce_gap = 0;
      if (!prev_ce && ({vif.hcnt, vif.vcnt, vif.HBlank, vif.HSync, vif.VBlank, vif.VSync}
                       !== {prev_h, prev_v, prev_f})) err_hold++;
      ls_exp = prev_ce && (vif.hcnt == 0);
      fs_exp = ls_exp && (vif.vcnt == 0) && (prev_v != 0);
      if (vif.line_start !== ls_exp || vif.frame_start !== fs_exp) err_pulse++;
      vs0 = m_pal ? VSP : VSN;
      if (vif.HBlank !== (int'(vif.hcnt) >= HA)) err_flag++;
      if (vif.HSync  !== (int'(vif.hcnt) >= HSS && int'(vif.hcnt) < HSS + HSL)) err_flag++;
      if (vif.VBlank !== (int'(vif.vcnt) >= VA)) err_flag++;
      if (vif.VSync  !== (int'(vif.vcnt) >= vs0 && int'(vif.vcnt) < vs0 + VSL)) err_flag++;
    end
    prev_ce = vif.ce_pix;
    prev_h  = vif.hcnt;
    prev_v  = vif.vcnt;
    prev_f  = {vif.HBlank, vif.HSync, vif.VBlank, vif.VSync};
  end

  typedef struct {
    logic pal;
    logic sd;
    int   frame_cycles;
    int   lines;
    int   line_starts;
    int   ce_count;
    int   vs_first;
    int   vs_last;
    int   vs_cycles;
  } rec_t;

  rec_t tbl[5];
  rec_t sb[$];

  task automatic wait_fs(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (vif.frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_vcnt(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (int'(vif.vcnt) == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Starts on a frame_start cycle; ends on the next frame_start cycle.
  task automatic measure(output rec_t o, output int hs_first, output int hs_last,
                         output int hb_first);
    int maxv;
    o = '{pal: vif.pal, sd: vif.scandouble, frame_cycles: 0, lines: 0, line_starts: 0,
          ce_count: 0, vs_first: 999, vs_last: -1, vs_cycles: 0};
    maxv = 0; hs_first = 999; hs_last = -1; hb_first = 999;
    for (int i = 0; i < 6000; i++) begin
      if (int'(vif.vcnt) > maxv) maxv = int'(vif.vcnt);
      if (vif.line_start) o.line_starts++;
      if (vif.ce_pix) o.ce_count++;
      if (vif.VSync) begin
        o.vs_cycles++;
        if (int'(vif.vcnt) < o.vs_first) o.vs_first = int'(vif.vcnt);
        if (int'(vif.vcnt) > o.vs_last) o.vs_last = int'(vif.vcnt);
      end
      if (vif.HSync) begin
        if (int'(vif.hcnt) < hs_first) hs_first = int'(vif.hcnt);
        if (int'(vif.hcnt) > hs_last) hs_last = int'(vif.hcnt);
      end
      if (vif.HBlank && int'(vif.hcnt) < hb_first) hb_first = int'(vif.hcnt);
      cyc();
      o.frame_cycles++;
      if (vif.frame_start) break;
    end
    o.lines = maxv + 1;
  endtask

  initial begin
    bit ok;
    int first, maxv, hsf, hsl, hbf, cnt;
    rec_t obs, exp_r;

    tbl[0] = '{1'b1, 1'b0, 2880, 18, 18, 360, 13, 14, 320};
    tbl[1] = '{1'b1, 1'b1, 2880, 18, 36, 720, 13, 14, 320};
    tbl[2] = '{1'b0, 1'b1, 2240, 14, 28, 560, 11, 12, 320};
    tbl[3] = '{1'b0, 1'b0, 2240, 14, 14, 280, 11, 12, 320};
    tbl[4] = '{1'b1, 1'b1, 2880, 18, 36, 720, 13, 14, 320};

    // Reset and first pixel enable
    vif.pal = 1'b0;
    vif.scandouble = 1'b0;
    reset_n = 1'b0;
    repeat (5) cyc();
    check("reset_ce_pix", vif.ce_pix, 0);
    check("reset_hcnt", vif.hcnt, 0);
    check("reset_vcnt", vif.vcnt, 0);
    check("reset_flags", {vif.HBlank, vif.HSync, vif.VBlank, vif.VSync}, 0);
    check("reset_pulses", {vif.line_start, vif.frame_start}, 0);
    reset_n = 1'b1;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (vif.ce_pix) begin
        first = k;
        break;
      end
    end
    check("first_ce_cycle", first, 8);
    cyc();
    check("hcnt_after_first_ce", vif.hcnt, 1);

    // PAL selected mid-frame: the NTSC frame still runs to its last line
    wait_vcnt(5, 3000, ok);
    check("reach_vcnt5", ok, 1);
    vif.pal = 1'b1;
    maxv = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (vif.frame_start) begin
        ok = 1'b1;
        break;
      end
      if (int'(vif.vcnt) > maxv) maxv = int'(vif.vcnt);
    end
    check("pal_switch_frame_start_seen", ok, 1);
    check("pal_switch_old_frame_last_line", maxv, VTN - 1);

    // Mode table through the scoreboard
    for (int i = 0; i < 5; i++) begin
      vif.pal = tbl[i].pal;
      vif.scandouble = tbl[i].sd;
      sb.push_back(tbl[i]);
      wait_fs(6000, ok);
      check($sformatf("row%0d_frame_start_seen", i), ok, 1);
      measure(obs, hsf, hsl, hbf);
      exp_r = sb.pop_front();
      check($sformatf("row%0d_frame_cycles", i), obs.frame_cycles, exp_r.frame_cycles);
      check($sformatf("row%0d_lines", i), obs.lines, exp_r.lines);
      check($sformatf("row%0d_line_starts", i), obs.line_starts, exp_r.line_starts);
      check($sformatf("row%0d_ce_count", i), obs.ce_count, exp_r.ce_count);
      check($sformatf("row%0d_vs_first", i), obs.vs_first, exp_r.vs_first);
      check($sformatf("row%0d_vs_last", i), obs.vs_last, exp_r.vs_last);
      check($sformatf("row%0d_vs_cycles", i), obs.vs_cycles, exp_r.vs_cycles);
      check($sformatf("row%0d_hs_first", i), hsf, HSS);
      check($sformatf("row%0d_hs_last", i), hsl, HSS + HSL - 1);
      check($sformatf("row%0d_hb_first", i), hbf, HA);
    end

    // Mid-frame reset during VSync
    vif.pal = 1'b0;
    vif.scandouble = 1'b0;
    wait_fs(6000, ok);
    check("pre_reset_frame_start_seen", ok, 1);
    wait_vcnt(VSN + 1, 6000, ok);
    check("reach_vsync_line", ok, 1);
    check("vsync_before_reset", vif.VSync, 1);
    reset_n = 1'b0;
    cyc();
    check("vsync_after_reset", vif.VSync, 0);
    check("hcnt_after_reset", vif.hcnt, 0);
    check("vcnt_after_reset", vif.vcnt, 0);
    cnt = 0;
    repeat (3) begin
      cyc();
      if (vif.frame_start) cnt++;
    end
    check("no_frame_start_in_reset", cnt, 0);
    reset_n = 1'b1;
    cnt = 0;
    repeat (2 * H * CE) begin
      cyc();
      if (vif.VSync) cnt++;
    end
    check("no_vsync_after_release", cnt, 0);

    check("monitor_reset_state", err_rst, 0);
    check("monitor_ce_period", err_ce, 0);
    check("monitor_pixel_hold", err_hold, 0);
    check("monitor_start_pulses", err_pulse, 0);
    check("monitor_flag_consistency", err_flag, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
